// File: rtl/conway_sequencer.sv
// Generation controller for the Game of Life cell array: loads the board, paces
// generation-enable pulses (free-run or single-step) and halts on limit, stable or empty.
module conway_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int GEN_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_load,
   input  logic             cmd_run,
   input  logic             cmd_pause,
   input  logic             cmd_step,
   input  logic [GEN_W-1:0] gen_limit,
   input  logic             board_changed,
   input  logic             board_alive,
   output logic             array_rst,
   output logic             array_ena,
   output logic [GEN_W-1:0] generation,
   output logic [2:0]       fsm_state,
   output logic             busy,
   output logic             halt_limit,
   output logic             halt_stable,
   output logic             halt_empty
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_PAUSED = 3'd2,
      ST_RUN    = 3'd3,
      ST_STEP   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic [GEN_W-1:0] generation_q, generation_d;
   logic             array_rst_q, array_rst_d;
   logic             array_ena_q, array_ena_d;
   logic             busy_q, busy_d;
   logic             halt_limit_q, halt_limit_d;
   logic             halt_stable_q, halt_stable_d;
   logic             halt_empty_q, halt_empty_d;

   logic [GEN_W-1:0] gen_inc;
   logic             run_limit_hit;
   logic             step_limit_hit;

   // Generation count saturates rather than wrapping; a limit of zero disables the limit.
   always_comb begin
      gen_inc        = (generation_q == {GEN_W{1'b1}}) ? generation_q : generation_q + 1'b1;
      run_limit_hit  = (gen_limit != '0) && (gen_inc >= gen_limit);
      step_limit_hit = (gen_limit != '0) && (generation_q >= gen_limit);
   end

   always_comb begin
      state_d       = state_q;
      tick_d        = tick_q;
      generation_d  = generation_q;
      array_rst_d   = 1'b0;
      array_ena_d   = 1'b0;
      halt_limit_d  = halt_limit_q;
      halt_stable_d = halt_stable_q;
      halt_empty_d  = halt_empty_q;

      if (cmd_load) begin
         state_d       = ST_LOAD;
         array_rst_d   = 1'b1;
         generation_d  = '0;
         tick_d        = '0;
         halt_limit_d  = 1'b0;
         halt_stable_d = 1'b0;
         halt_empty_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_LOAD: begin
               state_d = ST_PAUSED;
            end
            ST_PAUSED, ST_DONE: begin
               // Pause outranks step and run even though it has nothing to do here.
               if (cmd_pause) begin
                  state_d = state_q;
               end else if (cmd_step) begin
                  state_d       = ST_STEP;
                  array_ena_d   = 1'b1;
                  generation_d  = gen_inc;
                  halt_limit_d  = 1'b0;
                  halt_stable_d = 1'b0;
                  halt_empty_d  = 1'b0;
               end else if (cmd_run) begin
                  state_d       = ST_RUN;
                  tick_d        = '0;
                  halt_limit_d  = 1'b0;
                  halt_stable_d = 1'b0;
                  halt_empty_d  = 1'b0;
               end
            end
            ST_STEP: begin
               if (step_limit_hit) begin
                  state_d      = ST_DONE;
                  halt_limit_d = 1'b1;
               end else begin
                  state_d = ST_PAUSED;
               end
            end
            ST_RUN: begin
               if (cmd_pause) begin
                  state_d = ST_PAUSED;
                  tick_d  = '0;
               end else if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (!board_alive) begin
                     state_d      = ST_DONE;
                     halt_empty_d = 1'b1;
                  end else if (!board_changed) begin
                     state_d       = ST_DONE;
                     halt_stable_d = 1'b1;
                  end else begin
                     array_ena_d  = 1'b1;
                     generation_d = gen_inc;
                     if (run_limit_hit) begin
                        state_d      = ST_DONE;
                        halt_limit_d = 1'b1;
                     end
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_STEP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         tick_q        <= '0;
         generation_q  <= '0;
         array_rst_q   <= 1'b0;
         array_ena_q   <= 1'b0;
         busy_q        <= 1'b0;
         halt_limit_q  <= 1'b0;
         halt_stable_q <= 1'b0;
         halt_empty_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_q        <= tick_d;
         generation_q  <= generation_d;
         array_rst_q   <= array_rst_d;
         array_ena_q   <= array_ena_d;
         busy_q        <= busy_d;
         halt_limit_q  <= halt_limit_d;
         halt_stable_q <= halt_stable_d;
         halt_empty_q  <= halt_empty_d;
      end
   end

   assign array_rst   = array_rst_q;
   assign array_ena   = array_ena_q;
   assign generation  = generation_q;
   assign fsm_state   = state_q;
   assign busy        = busy_q;
   assign halt_limit  = halt_limit_q;
   assign halt_stable = halt_stable_q;
   assign halt_empty  = halt_empty_q;

endmodule

// File: doc/conway_sequencer.md
Name: conway_sequencer

Overview:
- Generation controller for the Game of Life cell array.
- Loads the initial pattern by pulsing the array's reset, so every cell latches its state_0.
- Issues one-cycle generation-enable pulses, in free-run at a programmable rate or single-stepped.
- Counts generations and halts on a generation limit, a stable board or an empty board.
- Sits between the user/debounce logic and the cell-array rst/ena nets.

Parameters:
- TICK_DIV, 4, clock cycles between generation pulses in RUN; legal range 2..2^24.
- GEN_W, 16, width of the generation counter and of the limit input.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- cmd_load  input  1  single-cycle request to reload the board from state_0.
- cmd_run  input  1  single-cycle request to start free-running.
- cmd_pause  input  1  single-cycle request to stop free-running.
- cmd_step  input  1  single-cycle request to advance exactly one generation.
- gen_limit  input  GEN_W  halt after this many generations; 0 means no limit.
- board_changed  input  1  OR over all cells of (state_d != state_q).
- board_alive  input  1  OR over all cells of state_q.
- array_rst  output  1  drives the cell-array rst; registered.
- array_ena  output  1  drives the cell-array ena; registered.
- generation  output  GEN_W  number of generations since the last load.
- fsm_state  output  3  IDLE=0, LOAD=1, PAUSED=2, RUN=3, STEP=4, DONE=5.
- busy  output  1  high in LOAD, RUN or STEP.
- halt_limit  output  1  sticky flag: stopped because the generation limit was reached.
- halt_stable  output  1  sticky flag: stopped because the board stopped changing.
- halt_empty  output  1  sticky flag: stopped because no cell is alive.

Behaviour:
- Clock and reset: single clock domain (clk). rst is synchronous and active-high. All outputs are registered.
- Reset values: fsm_state=IDLE, array_rst=0, array_ena=0, generation=0, all halt flags 0, tick counter 0.
- Command priority, resolved within one cycle: load > pause > step > run. Lower-priority commands in the same cycle are dropped.
- IDLE: only cmd_load is accepted; run, step and pause are ignored because no board is loaded yet.
- cmd_load, accepted in any state including mid-RUN:
  - Next cycle: fsm_state=LOAD, array_rst=1 for exactly one cycle, generation=0, halt flags cleared, tick counter cleared.
  - The following cycle: fsm_state=PAUSED, array_rst=0.
  - Any array_ena pulse that would have coincided with the load is suppressed.
- PAUSED:
  - cmd_step: fsm_state=STEP for one cycle with array_ena=1 and generation+1. Then back to PAUSED, unless the limit is reached, in which case go to DONE with halt_limit set.
  - Step does not evaluate the stable or empty conditions.
  - cmd_run: go to RUN with the tick counter at 0.
- RUN:
  - The tick counter increments every cycle.
  - At the cycle where counter==TICK_DIV-1, evaluate in this order, sampling board_alive and board_changed on that edge:
    1. board_alive=0 -> DONE, halt_empty=1, no pulse.
    2. Otherwise board_changed=0 -> DONE, halt_stable=1, no pulse.
    3. Otherwise array_ena=1 for the next cycle, generation+1, counter reset to 0. If gen_limit!=0 and the new generation >= gen_limit -> DONE, halt_limit=1; the pulse is still issued.
  - First pulse appears TICK_DIV cycles after entering RUN. Pulse period is TICK_DIV.
  - cmd_pause in RUN goes to PAUSED with the counter cleared. A pause arriving on the tick edge wins: no pulse.
- DONE:
  - cmd_run clears the halt flags and enters RUN with the counter at 0.
  - cmd_step clears the flags and steps, as from PAUSED.
  - cmd_load reloads.
  - cmd_pause is ignored.
- Limit and counter edge cases:
  - gen_limit lower than the current generation on entry to RUN: halt at the first pulse.
  - generation saturates at all-ones and never wraps.
- array_ena and array_rst are never high in the same cycle. Each is high for at most one consecutive cycle.
- rst asserted mid-operation: next cycle matches the reset values above. No pulse is issued.

Test Plan:
- Reset, then cmd_run and cmd_step in IDLE -> state stays 0, array_ena never high. Then cmd_load -> array_rst high exactly 1 cycle, state 1 then 2, generation=0.
- TICK_DIV=4, gen_limit=3, board_alive=1, board_changed=1, cmd_run -> array_ena pulses at cycles 4, 8 and 12 after entry; generation reads 1, 2, 3; then state=5, halt_limit=1, busy=0.
- In RUN, drop board_changed to 0 before the 2nd tick -> no 2nd pulse, state=5, halt_stable=1, generation=1. Repeat with board_alive=0 -> halt_empty=1 (empty takes precedence when both are low).
- PAUSED, cmd_step three times spaced 3 cycles apart -> three single-cycle pulses, generation=3, state returns to 2 each time. cmd_step and cmd_run in the same cycle -> step only.
- RUN with cmd_pause on the exact tick edge -> no pulse, state=2. cmd_load during RUN -> array_rst pulse, generation=0, no array_ena in that window.
- rst asserted while in RUN mid-count -> next cycle all outputs at reset values, and generation=0xFFFF saturation is held on a separate run with gen_limit=0.
